// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A host-side bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_bus_pkg;

    // Sequencer states. IDLE must stay the encoding that reset forces.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_INTA_LOW,
        ST_INTA_GAP,
        ST_DONE
    } seq_state_e;

    // Number of INTA_n pulses the PIC expects per acknowledge.
    localparam int INTA_PULSES_8086 = 2;
    localparam int INTA_PULSES_8080 = 3;

    // First byte the PIC returns in 8080 mode (CALL opcode).
    localparam logic [7:0] CALL_OPCODE_8080 = 8'hCD;

    // Largest of three cycle counts; sizes the shared strobe timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pic_host_bus_sequencer_if.sv
// Host command/response handshake plus the 8259A pin-level bus.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready; host must hold a request until accepted.
interface pic_host_bus_sequencer_if;

    // Host request / response
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic        cmd_a0;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    // PIC pins
    logic        chip_select_n;
    logic        read_enable_n;
    logic        write_enable_n;
    logic        address;
    logic [7:0]  data_bus_out;
    logic        data_bus_io;
    logic [7:0]  data_bus_in;
    logic        interrupt;
    logic        interrupt_acknowledge_n;

    // Acknowledge result and status
    logic        vector_valid;
    logic [15:0] vector;
    logic        busy;

    // The sequencer: drives the PIC strobes and answers the host.
    modport master (
        input  cmd_valid, cmd_read, cmd_a0, cmd_data, data_bus_in, interrupt,
        output cmd_ready, rsp_valid, rsp_data,
        output chip_select_n, read_enable_n, write_enable_n, address,
        output data_bus_out, data_bus_io, interrupt_acknowledge_n,
        output vector_valid, vector, busy
    );

    // The environment: host plus PIC.
    modport slave (
        output cmd_valid, cmd_read, cmd_a0, cmd_data, data_bus_in, interrupt,
        input  cmd_ready, rsp_valid, rsp_data,
        input  chip_select_n, read_enable_n, write_enable_n, address,
        input  data_bus_out, data_bus_io, interrupt_acknowledge_n,
        input  vector_valid, vector, busy
    );

endinterface

// File: rtl/pic_strobe_timer.sv
// Load/count-down timer shared by every timed sequencer state.
// Latency: expired rises load_val clocks after the load cycle.
// Backpressure: none; load always wins over counting.
module pic_strobe_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Reload on state entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/pic_host_bus_sequencer.sv
// Host-side 8259A initiator: timed CS_n/WR_n/RD_n/A0 cycles and INTA_n acknowledge.
// Latency: write accept->DONE = 2*SETUP+STROBE+1 clocks; INTA = pulses*STROBE+gaps+1.
// Backpressure: cmd_ready only in IDLE with no INT pending; no request queue.
module pic_host_bus_sequencer
    import pic_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int GAP_CYCLES    = 1,
    parameter bit MODE_8086     = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    pic_host_bus_sequencer_if.master   bus
);

    localparam int MAX_CYCLES = max3(STROBE_CYCLES, SETUP_CYCLES, GAP_CYCLES);
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    // Timer loads N-1 so the Nth cycle of a state is the one that sees expired.
    localparam logic [TW-1:0] LD_STROBE = TW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] LD_GAP    = TW'(GAP_CYCLES - 1);

    localparam logic [1:0] LAST_PULSE =
        2'(MODE_8086 ? (INTA_PULSES_8086 - 1) : (INTA_PULSES_8080 - 1));

    seq_state_e  state_q,    state_d;
    logic        read_q,     read_d;
    logic        a0_q,       a0_d;
    logic [7:0]  data_q,     data_d;
    logic        inta_q,     inta_d;
    logic [1:0]  pcnt_q,     pcnt_d;
    logic [7:0]  byte2_q,    byte2_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [15:0] vector_q,   vector_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

    pic_strobe_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state and pin decode; pins are pure functions of the registered state.
    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        a0_d       = a0_q;
        data_d     = data_q;
        inta_d     = inta_q;
        pcnt_d     = pcnt_q;
        byte2_d    = byte2_q;
        rsp_data_d = rsp_data_q;
        vector_d   = vector_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        bus.cmd_ready               = 1'b0;
        bus.rsp_valid               = 1'b0;
        bus.vector_valid            = 1'b0;
        bus.chip_select_n           = 1'b1;
        bus.read_enable_n           = 1'b1;
        bus.write_enable_n          = 1'b1;
        bus.interrupt_acknowledge_n = 1'b1;
        bus.address                 = 1'b0;
        bus.data_bus_out            = 8'h00;
        bus.data_bus_io             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending INT beats a host request; the request stays held.
                if (bus.interrupt) begin
                    state_d  = ST_INTA_LOW;
                    inta_d   = 1'b1;
                    pcnt_d   = 2'd0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end else if (bus.cmd_valid && !reset) begin
                    bus.cmd_ready = 1'b1;
                    state_d  = ST_SETUP;
                    inta_d   = 1'b0;
                    read_d   = bus.cmd_read;
                    a0_d     = bus.cmd_a0;
                    data_d   = bus.cmd_data;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end

            ST_SETUP: begin
                bus.chip_select_n = 1'b0;
                bus.address       = a0_q;
                bus.data_bus_io   = ~read_q;
                bus.data_bus_out  = read_q ? 8'h00 : data_q;
                if (tmr_expired) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end
            end

            ST_STROBE: begin
                bus.chip_select_n  = 1'b0;
                bus.address        = a0_q;
                bus.data_bus_io    = ~read_q;
                bus.data_bus_out   = read_q ? 8'h00 : data_q;
                bus.read_enable_n  = ~read_q;
                bus.write_enable_n = read_q;
                if (tmr_expired) begin
                    // Sample as late as possible, just before RD_n rises.
                    if (read_q) begin
                        rsp_data_d = bus.data_bus_in;
                    end
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end

            ST_HOLD: begin
                bus.chip_select_n = 1'b0;
                bus.address       = a0_q;
                bus.data_bus_io   = ~read_q;
                bus.data_bus_out  = read_q ? 8'h00 : data_q;
                if (tmr_expired) begin
                    state_d = ST_DONE;
                end
            end

            ST_INTA_LOW: begin
                bus.interrupt_acknowledge_n = 1'b0;
                if (tmr_expired) begin
                    // Slot 1 is the low call-address byte in 8080 mode.
                    if (pcnt_q == 2'd1) begin
                        byte2_d = bus.data_bus_in;
                    end
                    if (pcnt_q == LAST_PULSE) begin
                        vector_d = MODE_8086 ? {8'h00, bus.data_bus_in}
                                             : {bus.data_bus_in, byte2_q};
                        state_d  = ST_DONE;
                    end else begin
                        pcnt_d   = pcnt_q + 2'd1;
                        state_d  = ST_INTA_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_GAP;
                    end
                end
            end

            ST_INTA_GAP: begin
                if (tmr_expired) begin
                    state_d  = ST_INTA_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end
            end

            ST_DONE: begin
                bus.rsp_valid    = read_q & ~inta_q;
                bus.vector_valid = inta_q;
                state_d          = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            read_q     <= 1'b0;
            a0_q       <= 1'b0;
            data_q     <= 8'h00;
            inta_q     <= 1'b0;
            pcnt_q     <= 2'd0;
            byte2_q    <= 8'h00;
            rsp_data_q <= 8'h00;
            vector_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            a0_q       <= a0_d;
            data_q     <= data_d;
            inta_q     <= inta_d;
            pcnt_q     <= pcnt_d;
            byte2_q    <= byte2_d;
            rsp_data_q <= rsp_data_d;
            vector_q   <= vector_d;
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.vector   = vector_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pic_host_bus_sequencer.sv
// Directed bench for the 8259A host bus sequencer, 8086 and 8080 instances.
// Latency: n/a.
// Backpressure: host holds cmd_valid until cmd_ready.
module tb_pic_host_bus_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pic_host_bus_sequencer_if bus86 ();
    pic_host_bus_sequencer_if bus80 ();

    pic_host_bus_sequencer #(.MODE_8086(1'b1)) dut86 (
        .clock (clk),
        .reset (rst),
        .bus   (bus86)
    );

    pic_host_bus_sequencer #(.MODE_8086(1'b0)) dut80 (
        .clock (clk),
        .reset (rst),
        .bus   (bus80)
    );

    // PIC stub: returns table bytes on successive INTA pulses, read_dat otherwise.
    logic [7:0] read_dat = 8'h00;
    logic [7:0] tbl86_0 = 8'h00, tbl86_1 = 8'h00, tbl86_2 = 8'h00;
    logic [7:0] tbl80_0 = 8'h00, tbl80_1 = 8'h00, tbl80_2 = 8'h00;
    logic [7:0] inta_dat86 = 8'h00, inta_dat80 = 8'h00;
    logic       prev86 = 1'b1, prev80 = 1'b1;
    int         fall86 = 0, fall80 = 0;
    int         base86 = 0, base80 = 0;
    logic       mon_en = 1'b0;
    int         excl_viol = 0;

    always @(negedge clk) begin
        prev86 <= bus86.interrupt_acknowledge_n;
        prev80 <= bus80.interrupt_acknowledge_n;
        if (prev86 && !bus86.interrupt_acknowledge_n) begin
            inta_dat86 <= (fall86 - base86 == 0) ? tbl86_0 :
                          (fall86 - base86 == 1) ? tbl86_1 : tbl86_2;
            fall86 <= fall86 + 1;
        end
        if (prev80 && !bus80.interrupt_acknowledge_n) begin
            inta_dat80 <= (fall80 - base80 == 0) ? tbl80_0 :
                          (fall80 - base80 == 1) ? tbl80_1 : tbl80_2;
            fall80 <= fall80 + 1;
        end
        if (mon_en && ((!bus86.chip_select_n && !bus86.interrupt_acknowledge_n) ||
                       (!bus86.read_enable_n && !bus86.write_enable_n) ||
                       (!bus80.chip_select_n && !bus80.interrupt_acknowledge_n) ||
                       (!bus80.read_enable_n && !bus80.write_enable_n))) begin
            excl_viol <= excl_viol + 1;
        end
    end

    always_comb bus86.data_bus_in = bus86.interrupt_acknowledge_n ? read_dat : inta_dat86;
    always_comb bus80.data_bus_in = bus80.interrupt_acknowledge_n ? read_dat : inta_dat80;

    // Per-cycle trace, bit i = cycle i+1 after the accept/IDLE cycle.
    logic [15:0] t_cs, t_rd, t_wr, t_inta, t_rsp, t_vv, t_busy, t_io, t_addr;
    logic [7:0]  t_dbo2;

    task automatic run_trace(input bit use80, input int n);
        t_cs = '0; t_rd = '0; t_wr = '0; t_inta = '0; t_rsp = '0;
        t_vv = '0; t_busy = '0; t_io = '0; t_addr = '0; t_dbo2 = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus86.cmd_valid = 1'b0; bus80.cmd_valid = 1'b0;
                bus86.interrupt = 1'b0; bus80.interrupt = 1'b0;
            end
            #1;
            if (use80) begin
                t_cs[4'(i)]   = bus80.chip_select_n;
                t_rd[4'(i)]   = bus80.read_enable_n;
                t_wr[4'(i)]   = bus80.write_enable_n;
                t_inta[4'(i)] = bus80.interrupt_acknowledge_n;
                t_rsp[4'(i)]  = bus80.rsp_valid;
                t_vv[4'(i)]   = bus80.vector_valid;
                t_busy[4'(i)] = bus80.busy;
                t_io[4'(i)]   = bus80.data_bus_io;
                t_addr[4'(i)] = bus80.address;
                if (i == 1) t_dbo2 = bus80.data_bus_out;
            end else begin
                t_cs[4'(i)]   = bus86.chip_select_n;
                t_rd[4'(i)]   = bus86.read_enable_n;
                t_wr[4'(i)]   = bus86.write_enable_n;
                t_inta[4'(i)] = bus86.interrupt_acknowledge_n;
                t_rsp[4'(i)]  = bus86.rsp_valid;
                t_vv[4'(i)]   = bus86.vector_valid;
                t_busy[4'(i)] = bus86.busy;
                t_io[4'(i)]   = bus86.data_bus_io;
                t_addr[4'(i)] = bus86.address;
                if (i == 1) t_dbo2 = bus86.data_bus_out;
            end
        end
    endtask

    task automatic issue_cmd(input logic rd, input logic a0, input logic [7:0] dat);
        @(posedge clk); #1;
        bus86.cmd_read  = rd;
        bus86.cmd_a0    = a0;
        bus86.cmd_data  = dat;
        bus86.cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus86.cmd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({bus86.chip_select_n, bus86.read_enable_n, bus86.write_enable_n,
             bus86.interrupt_acknowledge_n} !== 4'hF) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 1111", {bus86.chip_select_n,
                     bus86.read_enable_n, bus86.write_enable_n, bus86.interrupt_acknowledge_n});
        end
        total++;
        if ({bus86.cmd_ready, bus86.rsp_valid, bus86.vector_valid, bus86.busy,
             bus86.address, bus86.data_bus_io} !== 6'b000000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus86.cmd_ready, bus86.rsp_valid,
                     bus86.vector_valid, bus86.busy, bus86.address, bus86.data_bus_io});
        end
        total++;
        if ({bus86.data_bus_out, bus86.rsp_data, bus86.vector} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {bus86.data_bus_out, bus86.rsp_data, bus86.vector});
        end
        total++;
        if ({bus80.chip_select_n, bus80.interrupt_acknowledge_n, bus80.busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset_8080: got %b want 110", {bus80.chip_select_n,
                     bus80.interrupt_acknowledge_n, bus80.busy});
        end
        bus86.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        issue_cmd(1'b0, 1'b0, 8'h13);
        #1;
        total++;
        if (bus86.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL write_accept: cmd_ready=%b want 1", bus86.cmd_ready);
        end
        run_trace(1'b0, 6);
        total++;
        if (t_cs !== 16'h0030) begin bad++; $display("FAIL write_cs: got %h want 0030", t_cs); end
        total++;
        if (t_wr !== 16'h0039) begin bad++; $display("FAIL write_wr: got %h want 0039", t_wr); end
        total++;
        if (t_rd !== 16'h003F) begin bad++; $display("FAIL write_rd: got %h want 003f", t_rd); end
        total++;
        if (t_io !== 16'h000F) begin bad++; $display("FAIL write_io: got %h want 000f", t_io); end
        total++;
        if (t_dbo2 !== 8'h13) begin bad++; $display("FAIL write_data: got %h want 13", t_dbo2); end
        total++;
        if (t_rsp !== 16'h0000) begin bad++; $display("FAIL write_rsp: got %h want 0000", t_rsp); end
        total++;
        if (t_busy !== 16'h001F) begin bad++; $display("FAIL write_busy: got %h want 001f", t_busy); end
        total++;
        if (t_addr !== 16'h0000) begin bad++; $display("FAIL write_addr0: got %h want 0000", t_addr); end
    endtask

    task automatic test_write_a1();
        issue_cmd(1'b0, 1'b1, 8'hA5);
        #1;
        run_trace(1'b0, 6);
        total++;
        if (t_addr !== 16'h000F) begin bad++; $display("FAIL write_addr1: got %h want 000f", t_addr); end
        total++;
        if (t_dbo2 !== 8'hA5) begin bad++; $display("FAIL write_a1_data: got %h want a5", t_dbo2); end
    endtask

    task automatic test_read();
        read_dat = 8'h5A;
        issue_cmd(1'b1, 1'b0, 8'hEE);
        #1;
        total++;
        if (bus86.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL read_accept: cmd_ready=%b want 1", bus86.cmd_ready);
        end
        run_trace(1'b0, 6);
        total++;
        if (t_rd !== 16'h0039) begin bad++; $display("FAIL read_rd: got %h want 0039", t_rd); end
        total++;
        if (t_wr !== 16'h003F) begin bad++; $display("FAIL read_wr: got %h want 003f", t_wr); end
        total++;
        if (t_io !== 16'h0000) begin bad++; $display("FAIL read_io: got %h want 0000", t_io); end
        total++;
        if (t_rsp !== 16'h0010) begin bad++; $display("FAIL read_rsp: got %h want 0010", t_rsp); end
        total++;
        if (bus86.rsp_data !== 8'h5A) begin
            bad++; $display("FAIL read_data: got %h want 5a", bus86.rsp_data);
        end
    endtask

    task automatic test_inta_8086();
        tbl86_0 = 8'hFF; tbl86_1 = 8'h4B; tbl86_2 = 8'h00;
        base86 = fall86;
        @(posedge clk); #1;
        bus86.interrupt = 1'b1;
        run_trace(1'b0, 7);
        total++;
        if (t_inta !== 16'h0064) begin bad++; $display("FAIL inta86_pulses: got %h want 0064", t_inta); end
        total++;
        if (t_vv !== 16'h0020) begin bad++; $display("FAIL inta86_vv: got %h want 0020", t_vv); end
        total++;
        if (t_cs !== 16'h007F) begin bad++; $display("FAIL inta86_cs: got %h want 007f", t_cs); end
        total++;
        if (t_busy !== 16'h003F) begin bad++; $display("FAIL inta86_busy: got %h want 003f", t_busy); end
        total++;
        if (bus86.vector !== 16'h004B) begin
            bad++; $display("FAIL inta86_vector: got %h want 004b", bus86.vector);
        end
        total++;
        if (fall86 - base86 != 2) begin
            bad++; $display("FAIL inta86_count: got %0d want 2", fall86 - base86);
        end
    endtask

    task automatic test_inta_8080();
        tbl80_0 = 8'hCD; tbl80_1 = 8'h20; tbl80_2 = 8'h01;
        base80 = fall80;
        @(posedge clk); #1;
        bus80.interrupt = 1'b1;
        run_trace(1'b1, 10);
        total++;
        if (t_inta !== 16'h0324) begin bad++; $display("FAIL inta80_pulses: got %h want 0324", t_inta); end
        total++;
        if (t_vv !== 16'h0100) begin bad++; $display("FAIL inta80_vv: got %h want 0100", t_vv); end
        total++;
        if (t_busy !== 16'h01FF) begin bad++; $display("FAIL inta80_busy: got %h want 01ff", t_busy); end
        total++;
        if (bus80.vector !== 16'h0120) begin
            bad++; $display("FAIL inta80_vector: got %h want 0120", bus80.vector);
        end
        total++;
        if (fall80 - base80 != 3) begin
            bad++; $display("FAIL inta80_count: got %0d want 3", fall80 - base80);
        end
    endtask

    task automatic test_int_vs_cmd();
        int vv_cyc;
        int acc_cyc;
        vv_cyc  = -1;
        acc_cyc = -1;
        tbl86_0 = 8'hFF; tbl86_1 = 8'h4B;
        base86 = fall86;
        @(posedge clk); #1;
        bus86.interrupt = 1'b1;
        bus86.cmd_read  = 1'b0;
        bus86.cmd_a0    = 1'b1;
        bus86.cmd_data  = 8'h3C;
        bus86.cmd_valid = 1'b1;
        #1;
        total++;
        if (bus86.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL prio_ready: cmd_ready=%b want 0", bus86.cmd_ready);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus86.interrupt = 1'b0;
            if (acc_cyc >= 0) bus86.cmd_valid = 1'b0;
            #1;
            if (bus86.vector_valid === 1'b1 && vv_cyc < 0) vv_cyc = i + 1;
            if (bus86.cmd_ready === 1'b1 && acc_cyc < 0) acc_cyc = i + 1;
        end
        total++;
        if (vv_cyc != 6) begin bad++; $display("FAIL prio_vv_cycle: got %0d want 6", vv_cyc); end
        total++;
        if (acc_cyc != 7) begin bad++; $display("FAIL prio_accept_cycle: got %0d want 7", acc_cyc); end
        total++;
        if (bus86.busy !== 1'b0) begin bad++; $display("FAIL prio_idle_after: busy=%b want 0", bus86.busy); end
    endtask

    task automatic test_reset_mid_strobe();
        int rsp_seen;
        rsp_seen = 0;
        read_dat = 8'h77;
        issue_cmd(1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        bus86.cmd_valid = 1'b0;
        @(posedge clk); #2;
        total++;
        if (bus86.read_enable_n !== 1'b0) begin
            bad++; $display("FAIL rst_in_strobe: rd_n=%b want 0", bus86.read_enable_n);
        end
        rst = 1'b1;
        @(posedge clk); #2;
        total++;
        if ({bus86.chip_select_n, bus86.read_enable_n, bus86.write_enable_n,
             bus86.interrupt_acknowledge_n, bus86.busy, bus86.rsp_valid} !== 6'b111100) begin
            bad++;
            $display("FAIL rst_abort: got %b want 111100", {bus86.chip_select_n, bus86.read_enable_n,
                     bus86.write_enable_n, bus86.interrupt_acknowledge_n, bus86.busy, bus86.rsp_valid});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            if (bus86.rsp_valid !== 1'b0 || bus86.busy !== 1'b0) rsp_seen++;
        end
        total++;
        if (rsp_seen != 0) begin bad++; $display("FAIL rst_no_rsp: got %0d active cycles want 0", rsp_seen); end
        total++;
        if (bus86.rsp_data !== 8'h00) begin
            bad++; $display("FAIL rst_rsp_data: got %h want 00", bus86.rsp_data);
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (excl_viol != 0) begin
            bad++; $display("FAIL strobe_overlap: got %0d cycles want 0", excl_viol);
        end
    endtask

    initial begin
        bus86.cmd_valid = 1'b0; bus86.cmd_read = 1'b0; bus86.cmd_a0 = 1'b0;
        bus86.cmd_data  = 8'h00; bus86.interrupt = 1'b0;
        bus80.cmd_valid = 1'b0; bus80.cmd_read = 1'b0; bus80.cmd_a0 = 1'b0;
        bus80.cmd_data  = 8'h00; bus80.interrupt = 1'b0;

        test_reset();
        mon_en = 1'b1;
        test_write();
        test_write_a1();
        test_read();
        test_inta_8086();
        test_inta_8080();
        test_int_vs_cmd();
        test_reset_mid_strobe();
        test_exclusive();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
